sort_collect: RTL and testbench
===============================

// Module: sort_collect
// PURPOSE
//  Receive-side partner of the bubble-sort engine's serial result port.
//  - Captures the DATA_N words the sorter streams out on out_vld/data_out.
//  - Reassembles them into a parallel array and signals completion.
//  - Flags a stalled stream (timeout) and, optionally, out-of-order data.
//  - Sits between the sorter interface and the consumer or scoreboard logic.
// PARAMETERS
//  DATA_W   4   width of one data word, in bits
//  DATA_N   4   number of words per sort result (>=2)
//  TIMEOUT  16  maximum idle cycles allowed between beats while collecting (>=1)
// PORTS
//  clk          in   1              single clock, rising edge
//  rst          in   1              synchronous reset, active-high
//  start_sort   in   1              arms the collector (same pulse that starts the sorter)
//  in_data      in   DATA_W         serial word (sorter data_out)
//  in_vld       in   1              in_data valid this cycle (sorter out_vld)
//  res_data     out  DATA_N*DATA_W  result array; word k at [k*DATA_W +: DATA_W]
//  res_done     out  1              one-cycle pulse: res_data holds a new complete result
//  busy         out  1              high while collecting
//  err_timeout  out  1              sticky; the stream stalled
//  err_order    out  1              sticky; a beat was smaller than the previous beat
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (res_data, res_done, busy, err_*); beat and gap counters 0.
//  FSM states: IDLE, COLLECT, DONE.
//  IDLE
//   - start_sort=1: clear err_timeout/err_order, beat_cnt=0, gap_cnt=0, go to COLLECT.
//   - in_vld is ignored.
//  COLLECT (busy=1)
//   - in_vld=1: write in_data into shadow[beat_cnt], beat_cnt++, gap_cnt=0.
//   - Beat with beat_cnt==DATA_N-1: copy the shadow (including this beat) into res_data, go to DONE.
//   - in_vld=0: gap_cnt++. When gap_cnt reaches TIMEOUT, set err_timeout and go to IDLE.
//   - On timeout: no res_done, and res_data keeps its previous value.
//   - start_sort=1 restarts the capture: beat_cnt=0, gap_cnt=0, errors cleared.
//     If in_vld is also 1 in that cycle, the restart wins and the beat is dropped.
//  DONE (one cycle)
//   - res_done=1, busy=0, then go to IDLE.
//   - A start_sort in this cycle re-arms (go to COLLECT) after the pulse.
//  Latency: res_done rises on the clock edge after the DATA_N-th beat is sampled.
//  res_data changes only at completion and holds until the next completion. It never shows a partial result.
//  beat_cnt width is $clog2(DATA_N); it never wraps because completion occurs at DATA_N-1.
//  gap_cnt saturates at TIMEOUT.
//  Any beats beyond DATA_N (arriving in DONE or IDLE) are ignored.
//  rst asserted mid-collection: the capture is aborted immediately and every output returns to its reset value.
// CONFIGURATION
//  SORT_CHK_EN defined
//   - Each beat after the first in a capture is compared (unsigned) with the previous beat.
//   - in_data < previous sets err_order (sticky until the next start_sort or rst).
//   - Equal values are legal.
//   - The capture continues regardless, and res_done still fires.
//  SORT_CHK_EN undefined
//   - No compare logic and no previous-beat register.
//   - err_order is tied to 0.
// TESTING (DATA_W=4, DATA_N=4, TIMEOUT=16)
//  T1 Normal:
//   - Stimulus: start_sort, then beats 1,3,7,C on consecutive cycles.
//   - Response: res_done pulses once, 1 cycle after beat C; res_data={C,7,3,1} (word0=1); errors 0.
//  T2 Gapped:
//   - Stimulus: beats 2,2,5,9 with 3 idle cycles between each.
//   - Response: same as T1 pattern, res_data={9,5,2,2}; err_timeout=0; busy=1 throughout the capture.
//  T3 Timeout:
//   - Stimulus: start_sort, beats 4,6, then in_vld=0 for 16 cycles.
//   - Response: err_timeout=1; busy falls; no res_done; res_data keeps its old value.
//  T4 Order (with SORT_CHK_EN):
//   - Stimulus: beats 5,3,8,9.
//   - Response: err_order=1 after beat 3; res_done fires; res_data={9,8,3,5}.
//   - Same stimulus without SORT_CHK_EN: err_order=0.
//  T5 Restart and reset:
//   - Stimulus: start_sort, beats A,B, then start_sort again, then beats 0,1,2,3.
//   - Response: res_data={3,2,1,0}.
//   - Then rst for 1 cycle after 2 beats of a new capture: all outputs 0, state IDLE.
//  T6 Stray beats:
//   - Stimulus: in_vld pulses in IDLE, and a 5th beat after completion.
//   - Response: no res_done; res_data unchanged.

Source files
------------

// File: rtl/sort_collect.sv
// Collects the serial result stream of the bubble-sort engine into a parallel array.
// Optional monotonic-order checker enabled by defining SORT_CHK_EN.
module sort_collect #(
    parameter int DATA_W  = 4,
    parameter int DATA_N  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_sort,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_vld,
    output logic [DATA_N*DATA_W-1:0] res_data,
    output logic                     res_done,
    output logic                     busy,
    output logic                     err_timeout,
    output logic                     err_order
);

    localparam int BEAT_W = $clog2(DATA_N);
    localparam int GAP_W  = $clog2(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_N - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] shadow [DATA_N];
    logic              beat_en;

    // A restart in the same cycle as a beat drops the beat.
    assign beat_en = (state == COLLECT) && in_vld && !start_sort;

    // NOTE: the shadow buffer has no reset; every slot is rewritten before
    // res_data is loaded from it, so resetting it would only cost logic.
    always_ff @(posedge clk) begin
        if (beat_en)
            shadow[beat_cnt] <= in_data;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            gap_cnt     <= '0;
            res_data    <= '0;
            res_done    <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            res_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_sort) begin
                        state       <= COLLECT;
                        busy        <= 1'b1;
                        beat_cnt    <= '0;
                        gap_cnt     <= '0;
                        err_timeout <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                COLLECT: begin
                    if (start_sort) begin
                        beat_cnt    <= '0;
                        gap_cnt     <= '0;
                        err_timeout <= 1'b0;
                    end else if (in_vld) begin
                        gap_cnt <= '0;
                        if (beat_cnt == LAST_BEAT) begin
                            for (int k = 0; k < DATA_N - 1; k++)
                                res_data[k*DATA_W +: DATA_W] <= shadow[k];
                            res_data[(DATA_N-1)*DATA_W +: DATA_W] <= in_data;
                            res_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end else if (gap_cnt == GAP_W'(TIMEOUT - 1)) begin
                        // Stall: abandon the capture, res_data keeps the last good result.
                        gap_cnt     <= GAP_W'(TIMEOUT);
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SORT_CHK_EN
    logic [DATA_W-1:0] prev_data;
    logic              order_err;

    // The first beat of a capture has no predecessor and is never compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_data <= '0;
            order_err <= 1'b0;
        end else if (start_sort) begin
            order_err <= 1'b0;
        end else if (beat_en) begin
            if (beat_cnt != '0 && in_data < prev_data)
                order_err <= 1'b1;
            prev_data <= in_data;
        end
    end

    assign err_order = order_err;
`else
    assign err_order = 1'b0;
`endif

endmodule

// File: tb/tb_sort_collect.sv
// Directed bench for sort_collect (DATA_W=4, DATA_N=4, TIMEOUT=16).
// Expected err_order follows whether SORT_CHK_EN is defined for the build.
module tb_sort_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_sort;
    logic [3:0]  in_data;
    logic        in_vld;
    logic [15:0] res_data;
    logic        res_done;
    logic        busy;
    logic        err_timeout;
    logic        err_order;

    int checks = 0;
    int errors = 0;

`ifdef SORT_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    sort_collect #(.DATA_W(4), .DATA_N(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_sort (start_sort),
        .in_data    (in_data),
        .in_vld     (in_vld),
        .res_data   (res_data),
        .res_done   (res_done),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_order  (err_order)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        v;
        logic [3:0]  d;
        logic        done;
        logic        bsy;
        logic        eo;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic done, input logic bsy,
                              input logic et, input logic eo, input logic [15:0] rd);
        check($sformatf("%s res_done", tag), {31'd0, res_done}, {31'd0, done});
        check($sformatf("%s busy", tag), {31'd0, busy}, {31'd0, bsy});
        check($sformatf("%s err_timeout", tag), {31'd0, err_timeout}, {31'd0, et});
        check($sformatf("%s err_order", tag), {31'd0, err_order}, {31'd0, eo});
        check($sformatf("%s res_data", tag), {16'd0, res_data}, {16'd0, rd});
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic step(input logic s, input logic v, input logic [3:0] d);
        start_sort = s;
        in_vld     = v;
        in_data    = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] gap_beats [4];

        // T1 normal, T4 order, T5 restart, T6 stray beats, re-arm from DONE
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 16'hC731};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hC731};
        tbl[6]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'hC731};
        tbl[7]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 16'hC731};
        tbl[8]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, CHK,  16'hC731};
        tbl[9]  = '{1'b0, 1'b1, 4'h8, 1'b0, 1'b1, CHK,  16'hC731};
        tbl[10] = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b0, CHK,  16'h9835};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, CHK,  16'h9835};
        tbl[12] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h9835};
        tbl[13] = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 16'h9835};
        tbl[14] = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 16'h9835};
        tbl[15] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 16'h9835};
        tbl[16] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 16'h9835};
        tbl[17] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'h9835};
        tbl[18] = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h9835};
        tbl[19] = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'h3210};
        tbl[20] = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 16'h3210};
        tbl[21] = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 16'h3210};
        tbl[22] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h3210};
        tbl[23] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'h3210};
        tbl[24] = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h3210};
        tbl[25] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 16'h3210};
        tbl[26] = '{1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 16'h4321};
        tbl[27] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h4321};
        tbl[28] = '{1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 16'h4321};
        tbl[29] = '{1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 16'h4321};
        tbl[30] = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 16'h4321};
        tbl[31] = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 16'hBA98};

        rst        = 1'b1;
        start_sort = 1'b0;
        in_vld     = 1'b0;
        in_data    = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].d);
            check_outs($sformatf("vec%0d", i), tbl[i].done, tbl[i].bsy, 1'b0, tbl[i].eo, tbl[i].rd);
        end

        // T2: gapped beats, 3 idle cycles before each
        gap_beats[0] = 4'h2;
        gap_beats[1] = 4'h2;
        gap_beats[2] = 4'h5;
        gap_beats[3] = 4'h9;
        step(1'b1, 1'b0, 4'h0);
        check_outs("gap start", 1'b0, 1'b1, 1'b0, 1'b0, 16'hBA98);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0, 4'h0);
                check_outs($sformatf("gap b%0d idle%0d", b, g), 1'b0, 1'b1, 1'b0, 1'b0, 16'hBA98);
            end
            step(1'b0, 1'b1, gap_beats[b]);
            if (b < 3)
                check_outs($sformatf("gap beat%0d", b), 1'b0, 1'b1, 1'b0, 1'b0, 16'hBA98);
            else
                check_outs("gap last", 1'b1, 1'b0, 1'b0, 1'b0, 16'h9522);
        end
        step(1'b0, 1'b0, 4'h0);
        check_outs("gap after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h9522);

        // T3: timeout after exactly 16 idle cycles
        step(1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h4);
        step(1'b0, 1'b1, 4'h6);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 4'h0);
            if (i < 16)
                check_outs($sformatf("tmo idle%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 16'h9522);
            else
                check_outs("tmo expire", 1'b0, 1'b0, 1'b1, 1'b0, 16'h9522);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'h0);
            check_outs($sformatf("tmo sticky%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 16'h9522);
        end
        step(1'b1, 1'b0, 4'h0);
        check_outs("tmo clear", 1'b0, 1'b1, 1'b0, 1'b0, 16'h9522);

        // T5 tail: synchronous reset mid-capture
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h2);
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        check_outs("rst mid", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        step(1'b0, 1'b1, 4'h5);
        check_outs("rst idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 4'h6);
        check_outs("rst idle2", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
